cp0_regfile: RTL and testbench
==============================

CP0_REGFILE -- requirements
Module: cp0_regfile

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'h0000_0080, handler entry address for all exceptions and interrupts.
REQ-002 SHALL have parameter HW_INT_BIT, default 7, Cause/Status bit index of the timer interrupt (IP7/IM7).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port cp0Op  input  3  operation: 000 none, 001 MFC0, 010 MTC0, 011 SYSCALL, 100 ERET; other values are treated as none.
REQ-006 SHALL have port rd  input  5  CP0 register select (ins[15:11]).
REQ-007 SHALL have port wdata  input  32  MTC0 write data (GPR rt).
REQ-008 SHALL have port pc  input  32  address of the current instruction.
REQ-009 SHALL have port rdata  output  32  MFC0 read data, combinational from rd; 0 for unimplemented registers.
REQ-010 SHALL have port excReq  output  1  combinational: squash current instruction and redirect fetch this cycle.
REQ-011 SHALL have port excPc  output  32  redirect target, valid when excReq=1.

Function
REQ-012 SHALL implement Count(9), Compare(11), Status(12: bit0 IE, bit1 EXL, bits15:8 IM), Cause(13: bits15:8 IP, bits6:2 ExcCode), EPC(14); unwritable bits read 0.
REQ-013 SHALL increment Count by 1 every cycle, wrapping 32'hFFFF_FFFF to 0.
REQ-014 SHALL set Cause.IP[HW_INT_BIT] on the edge at which Count equals Compare; the bit SHALL stay set until Compare is written by MTC0.
REQ-015 SHALL define intTake = IP[HW_INT_BIT] & IM[HW_INT_BIT] & IE & ~EXL, evaluated on current register state.
REQ-016 SHALL resolve each cycle with priority: intTake > SYSCALL > ERET > MTC0 > none.
REQ-017 On intTake: excReq=1, excPc=EXC_VECTOR; at the edge, EPC<=pc, ExcCode<=0, EXL<=1; any MTC0 or ERET that cycle is discarded.
REQ-018 On SYSCALL without intTake: excReq=1, excPc=EXC_VECTOR; at the edge, EPC<=pc, ExcCode<=8, EXL<=1.
REQ-019 On ERET without a higher-priority event: excReq=1, excPc=EPC (pre-edge value); at the edge, EXL<=0.
REQ-020 On MTC0 without a higher-priority event: write wdata to register rd at the edge; writes to Cause SHALL affect only IP[1:0]; writes to unimplemented registers SHALL be ignored.
REQ-021 An MTC0 to Count SHALL override that cycle's increment; an MTC0 to Compare SHALL clear IP[HW_INT_BIT] in the same edge, and the new Compare SHALL be used for the match from the next cycle.
REQ-022 MFC0 SHALL have zero latency, return pre-edge register values, and not change state.
REQ-023 SYSCALL while EXL=1 SHALL still overwrite EPC and ExcCode (no nesting protection); interrupts SHALL be masked while EXL=1.

Reset
REQ-024 On clk edge with rst_n=0: Count, Compare, Status, Cause and EPC SHALL be set to 0, and the same edge SHALL perform no increment or write.
REQ-025 While rst_n=0, excReq SHALL be 0; rdata SHALL reflect the current register values.
REQ-026 Reset asserted during any operation SHALL take precedence over that cycle's event.

Structure
REQ-027 Shared package cp0_pkg SHALL hold the cp0Op encodings, register indices (9, 11, 12, 13, 14) and ExcCode values (INT=0, SYS=8).
REQ-028 Count/Compare/match logic SHALL be a sub-module cp0_timer, outputting the count value, compare value and a one-cycle match pulse.
REQ-029 Total RTL SHALL be 120-400 lines, with no latches and a single clock domain.

Verification
REQ-030 Reset, then apply MTC0 rd=12 wdata=32'h0000_8001, then MFC0 rd=12 -> rdata=32'h0000_8001.
REQ-031 SYSCALL at pc=32'h0000_3010 -> excReq=1, excPc=32'h0000_0080 that cycle; next cycle EPC=32'h0000_3010, Cause[6:2]=8, Status.EXL=1.
REQ-032 After REQ-031, ERET -> excReq=1, excPc=32'h0000_3010; next cycle EXL=0.
REQ-033 Status=32'h0000_8001 and Compare=Count+5 -> IP7 is set 5 cycles later; the next cycle gives excReq=1 with ExcCode=0; MTC0 Compare clears IP7.
REQ-034 Interrupt pending and SYSCALL in the same cycle -> interrupt wins, ExcCode=0, EPC=pc; MTC0 rd=9 wdata=32'hFFFF_FFFF -> Count=0 one cycle later (wrap).
REQ-035 rst_n=0 asserted in the same cycle as a SYSCALL -> excReq=0, and all registers read 0 afterwards.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 register file: operation encodings, register indices
// and exception codes.
package cp0_pkg;

  // cp0Op encodings; undefined values behave as OP_NONE
  localparam logic [2:0] OP_NONE    = 3'b000;
  localparam logic [2:0] OP_MFC0    = 3'b001;
  localparam logic [2:0] OP_MTC0    = 3'b010;
  localparam logic [2:0] OP_SYSCALL = 3'b011;
  localparam logic [2:0] OP_ERET    = 3'b100;

  // Implemented CP0 register numbers
  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  // Cause.ExcCode values
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer for CP0.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   count_we        load Count from wdata instead of incrementing
//   compare_we      load Compare from wdata
//   wdata           write data
//   count, compare  current register values
//   match           high while Count equals Compare (one cycle, since Count advances)
module cp0_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        match
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;

  always_comb begin
    count_d   = count_we ? wdata : count_q + 32'd1;
    compare_d = compare_we ? wdata : compare_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  // Compared on pre-edge values, so a new Compare only takes effect next cycle
  assign match   = (count_q == compare_q);

endmodule

// File: rtl/cp0_regfile.sv
// MIPS-style CP0 register file: Count, Compare, Status, Cause, EPC with timer
// interrupt, SYSCALL and ERET handling.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   cp0Op       operation (none / MFC0 / MTC0 / SYSCALL / ERET)
//   rd          CP0 register select
//   wdata       MTC0 write data
//   pc          address of the current instruction
//   rdata       combinational MFC0 read data
//   excReq      squash current instruction and redirect fetch
//   excPc       redirect target
module cp0_regfile #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
  parameter int unsigned HW_INT_BIT = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  cp0Op,
  input  logic [4:0]  rd,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic        excReq,
  output logic [31:0] excPc
);

  import cp0_pkg::*;

  logic        ie_q, ie_d;
  logic        exl_q, exl_d;
  logic [7:0]  im_q, im_d;
  logic [7:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic [31:0] count, compare;
  logic        match;

  logic is_sys, is_eret, is_mtc0;
  logic int_take, take_exc, do_eret, do_mtc0;
  logic count_we, compare_we;

  always_comb begin
    is_sys   = (cp0Op == OP_SYSCALL);
    is_eret  = (cp0Op == OP_ERET);
    is_mtc0  = (cp0Op == OP_MTC0);
    int_take = ip_q[HW_INT_BIT] & im_q[HW_INT_BIT] & ie_q & ~exl_q;
    take_exc = int_take | is_sys;
    do_eret  = is_eret & ~take_exc;
    do_mtc0  = is_mtc0 & ~take_exc;
    count_we   = do_mtc0 & (rd == REG_COUNT);
    compare_we = do_mtc0 & (rd == REG_COMPARE);
    excReq   = rst_n & (take_exc | do_eret);
    excPc    = take_exc ? EXC_VECTOR : epc_q;
  end

  cp0_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_we   (count_we),
    .compare_we (compare_we),
    .wdata      (wdata),
    .count      (count),
    .compare    (compare),
    .match      (match)
  );

  always_comb begin
    ie_d       = ie_q;
    exl_d      = exl_q;
    im_d       = im_q;
    ip_d       = ip_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;

    if (take_exc) begin
      epc_d      = pc;
      exc_code_d = int_take ? EXC_INT : EXC_SYS;
      exl_d      = 1'b1;
    end else if (do_eret) begin
      exl_d = 1'b0;
    end else if (do_mtc0) begin
      case (rd)
        REG_STATUS: begin
          im_d  = wdata[15:8];
          exl_d = wdata[1];
          ie_d  = wdata[0];
        end
        REG_CAUSE: ip_d[1:0] = wdata[9:8];  // only the software interrupt bits
        REG_EPC:   epc_d = wdata;
        default: ;
      endcase
    end

    if (match) ip_d[HW_INT_BIT] = 1'b1;
    // Writing Compare acknowledges the timer interrupt, even on a coincident match
    if (compare_we) ip_d[HW_INT_BIT] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ie_q       <= 1'b0;
      exl_q      <= 1'b0;
      im_q       <= 8'd0;
      ip_q       <= 8'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      ie_q       <= ie_d;
      exl_q      <= exl_d;
      im_q       <= im_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  always_comb begin
    case (rd)
      REG_COUNT:   rdata = count;
      REG_COMPARE: rdata = compare;
      REG_STATUS:  rdata = {16'd0, im_q, 6'd0, exl_q, ie_q};
      REG_CAUSE:   rdata = {16'd0, ip_q, 1'b0, exc_code_q, 2'd0};
      REG_EPC:     rdata = epc_q;
      default:     rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: directed scenarios plus randomized traffic,
// all checked against a register-level reference model.
module tb_cp0_regfile;

  localparam logic [31:0] VEC = 32'h0000_0080;
  localparam int HB = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  cp0Op;
  logic [4:0]  rd;
  logic [31:0] wdata, pc, rdata, excPc;
  logic        excReq;

  always #5 clk = ~clk;

  cp0_regfile #(
    .EXC_VECTOR (VEC),
    .HW_INT_BIT (HB)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cp0Op  (cp0Op),
    .rd     (rd),
    .wdata  (wdata),
    .pc     (pc),
    .rdata  (rdata),
    .excReq (excReq),
    .excPc  (excPc)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: architectural register contents
  logic [31:0] m_count, m_compare, m_status, m_cause, m_epc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] r);
    case (r)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_int();
    return m_cause[8+HB] & m_status[8+HB] & m_status[0] & ~m_status[1];
  endfunction

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_step();
    logic [31:0] next_count;
    logic        hit, cmp_wr;
    if (!rst_n) begin
      m_count = 0; m_compare = 0; m_status = 0; m_cause = 0; m_epc = 0;
    end else begin
      hit        = (m_count == m_compare);
      next_count = m_count + 32'd1;
      cmp_wr     = 1'b0;
      if (m_int()) begin
        m_epc = pc; m_cause[6:2] = 5'd0; m_status[1] = 1'b1;
      end else if (cp0Op == 3'd3) begin
        m_epc = pc; m_cause[6:2] = 5'd8; m_status[1] = 1'b1;
      end else if (cp0Op == 3'd4) begin
        m_status[1] = 1'b0;
      end else if (cp0Op == 3'd2) begin
        case (rd)
          5'd9:  next_count = wdata;
          5'd11: begin m_compare = wdata; cmp_wr = 1'b1; end
          5'd12: m_status = wdata & 32'h0000_FF03;
          5'd13: m_cause[9:8] = wdata[9:8];
          5'd14: m_epc = wdata;
          default: ;
        endcase
      end
      if (hit) m_cause[8+HB] = 1'b1;
      if (cmp_wr) m_cause[8+HB] = 1'b0;
      m_count = next_count;
    end
  endtask

  // Apply inputs for one cycle and check combinational outputs against the model
  task automatic drive(input logic rn, input logic [2:0] op, input logic [4:0] r,
                       input logic [31:0] wd, input logic [31:0] p);
    logic exp_req;
    logic exc;
    rst_n = rn; cp0Op = op; rd = r; wdata = wd; pc = p;
    #1;
    exc     = m_int() || (op == 3'd3);
    exp_req = rn && (exc || (op == 3'd4));
    check_eq("rdata", rdata, m_read(r));
    check_eq("excReq", {31'd0, excReq}, {31'd0, exp_req});
    if (exp_req) check_eq("excPc", excPc, exc ? VEC : m_epc);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cyc(input logic rn, input logic [2:0] op, input logic [4:0] r,
                     input logic [31:0] wd, input logic [31:0] p);
    drive(rn, op, r, wd, p);
    tick();
  endtask

  initial begin
    logic [31:0] c;
    logic [4:0]  rr;
    logic [2:0]  op;
    logic [31:0] wd;
    logic [4:0]  regs [5];
    regs[0] = 5'd9; regs[1] = 5'd11; regs[2] = 5'd12; regs[3] = 5'd13; regs[4] = 5'd14;

    rst_n = 1'b0; cp0Op = 3'd0; rd = 5'd0; wdata = 32'd0; pc = 32'd0;
    #2;
    tick();
    tick();

    // Reset state
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 3'd1, regs[i], 32'd0, 32'd0);
      check_eq("reset_reg", rdata, 32'd0);
      tick();
    end

    // Park Compare away from Count, then Status write/readback
    cyc(1'b1, 3'd2, 5'd11, 32'h0001_0000, 32'h100);
    cyc(1'b1, 3'd2, 5'd12, 32'h0000_8001, 32'h104);
    drive(1'b1, 3'd1, 5'd12, 32'd0, 32'h108);
    check_eq("status_rd", rdata, 32'h0000_8001);
    tick();

    // SYSCALL then ERET
    drive(1'b1, 3'd3, 5'd0, 32'd0, 32'h0000_3010);
    check_eq("sys_req", {31'd0, excReq}, 32'd1);
    check_eq("sys_pc", excPc, VEC);
    tick();
    drive(1'b1, 3'd1, 5'd14, 32'd0, 32'h80);
    check_eq("sys_epc", rdata, 32'h0000_3010);
    tick();
    drive(1'b1, 3'd1, 5'd13, 32'd0, 32'h84);
    check_eq("sys_code", {27'd0, rdata[6:2]}, 32'd8);
    tick();
    drive(1'b1, 3'd1, 5'd12, 32'd0, 32'h88);
    check_eq("sys_exl", {31'd0, rdata[1]}, 32'd1);
    tick();
    drive(1'b1, 3'd4, 5'd0, 32'd0, 32'h8C);
    check_eq("eret_req", {31'd0, excReq}, 32'd1);
    check_eq("eret_pc", excPc, 32'h0000_3010);
    tick();
    drive(1'b1, 3'd1, 5'd12, 32'd0, 32'h3014);
    check_eq("eret_exl", {31'd0, rdata[1]}, 32'd0);
    tick();

    // Timer interrupt: Compare = Count + 5
    c = m_count;
    cyc(1'b1, 3'd2, 5'd11, c + 32'd5, 32'h3018);
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, 3'd1, 5'd13, 32'd0, 32'h4000);
      check_eq("ip7_timing", {31'd0, rdata[15]}, (k == 6) ? 32'd1 : 32'd0);
      if (k == 6) check_eq("int_req", {31'd0, excReq}, 32'd1);
      tick();
    end
    drive(1'b1, 3'd1, 5'd13, 32'd0, 32'h80);
    check_eq("int_cause", rdata, 32'h0000_8000);
    tick();
    drive(1'b1, 3'd1, 5'd14, 32'd0, 32'h84);
    check_eq("int_epc", rdata, 32'h0000_4000);
    tick();
    cyc(1'b1, 3'd2, 5'd11, 32'h7FFF_0000, 32'h88);
    drive(1'b1, 3'd1, 5'd13, 32'd0, 32'h8C);
    check_eq("ip7_clear", {31'd0, rdata[15]}, 32'd0);
    tick();
    cyc(1'b1, 3'd4, 5'd0, 32'd0, 32'h90);

    // Interrupt beats SYSCALL in the same cycle
    c = m_count;
    cyc(1'b1, 3'd2, 5'd11, c + 32'd1, 32'h5540);
    cyc(1'b1, 3'd0, 5'd0, 32'd0, 32'h5544);
    drive(1'b1, 3'd3, 5'd0, 32'd0, 32'h0000_5550);
    check_eq("prio_req", {31'd0, excReq}, 32'd1);
    tick();
    drive(1'b1, 3'd1, 5'd13, 32'd0, 32'h80);
    check_eq("prio_code", {27'd0, rdata[6:2]}, 32'd0);
    tick();
    drive(1'b1, 3'd1, 5'd14, 32'd0, 32'h84);
    check_eq("prio_epc", rdata, 32'h0000_5550);
    tick();
    cyc(1'b1, 3'd2, 5'd11, 32'h7FFF_0000, 32'h88);
    cyc(1'b1, 3'd4, 5'd0, 32'd0, 32'h8C);

    // Count wrap
    cyc(1'b1, 3'd2, 5'd9, 32'hFFFF_FFFF, 32'h5554);
    drive(1'b1, 3'd1, 5'd9, 32'd0, 32'h5558);
    check_eq("count_max", rdata, 32'hFFFF_FFFF);
    tick();
    drive(1'b1, 3'd1, 5'd9, 32'd0, 32'h555C);
    check_eq("count_wrap", rdata, 32'd0);
    tick();

    // Reset beats SYSCALL
    drive(1'b0, 3'd3, 5'd0, 32'd0, 32'h0000_6000);
    check_eq("rst_sys_req", {31'd0, excReq}, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 3'd1, regs[i], 32'd0, 32'h6004);
      check_eq("rst_clear", rdata, 32'd0);
      tick();
    end

    // Randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      case ($urandom_range(0, 5))
        0: rr = 5'd9;
        1: rr = 5'd11;
        2: rr = 5'd12;
        3: rr = 5'd13;
        4: rr = 5'd14;
        default: rr = 5'($urandom_range(0, 31));
      endcase
      op = 3'($urandom_range(0, 7));
      wd = $urandom;
      if (rr == 5'd11 && $urandom_range(0, 1) == 1) wd = m_count + 32'($urandom_range(1, 4));
      cyc(($urandom_range(0, 39) != 0), op, rr, wd, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
